fix_buf_read_sched: RTL and testbench

Owns the single-port FIX message buffer RAM and shares it between two requesters: the parser write stream and the host readout path behind the Avalon slave.
Sequences the readout of a completed message byte by byte, from index 0 up to the latched final index.
Exposes a status byte and a held read-data byte for the slave register file.
Parser writes have priority, limited by a starvation guard.

---
 rtl/fix_pkg.sv | 25 ++
 rtl/fix_buf_arb.sv | 56 +++++
 rtl/fix_buf_read_sched.sv | 150 +++++++++++++++
 tb/tb_fix_buf_read_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX message buffer read scheduler.
package fix_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } fix_rd_state_t;

  // Bit positions inside the status byte
  localparam int ST_READY = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_DONE  = 2;
  localparam int ST_OVRN  = 3;
  localparam int ST_CSUM  = 4;

  // Slave register map
  localparam int RSTAT = 0;
  localparam int RDATA = 1;
  localparam int CONN  = 6;

endpackage

// File: rtl/fix_buf_arb.sv
// Parser/reader arbiter for the single-port message buffer RAM, with a
// starvation guard that lets the reader through after STARVE_MAX parser wins.
module fix_buf_arb
  import fix_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  input  logic              par_wr_valid,
  input  logic [ADDR_W-1:0] par_wr_addr,
  input  logic [DATA_W-1:0] par_wr_data,
  output logic              par_wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata
);

  logic [3:0] starve_reg;
  logic       starved;
  logic       par_grant;

  // The mux is combinational so the RAM samples the winner's address in the
  // grant cycle; its registered read data is then valid one cycle later.
  always_comb begin
    starved   = rd_req && (starve_reg == 4'(STARVE_MAX));
    par_grant = !reset && par_wr_valid && !starved;
    rd_grant  = !reset && rd_req && !par_grant;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (par_grant) begin
      ram_addr  = par_wr_addr;
      ram_we    = 1'b1;
      ram_wdata = par_wr_data;
    end else if (rd_grant) begin
      ram_addr = rd_addr;
    end
  end

  assign par_wr_ready = par_grant;

  always_ff @(posedge clk) begin
    if (reset || !rd_req || rd_grant) begin
      starve_reg <= '0;
    end else if (par_grant) begin
      starve_reg <= starve_reg + 4'd1;
    end
  end

endmodule

// File: rtl/fix_buf_read_sched.sv
// FIX buffer read scheduler: byte-by-byte host readout of a completed message.
// Optional running checksum of popped bytes when FIX_BUF_CHECKSUM_EN is defined.
module fix_buf_read_sched
  import fix_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              par_wr_valid,
  input  logic [ADDR_W-1:0] par_wr_addr,
  input  logic [DATA_W-1:0] par_wr_data,
  output logic              par_wr_ready,
  input  logic              fix_message_sent,
  input  logic [ADDR_W-1:0] final_index,
  input  logic              host_start,
  input  logic              host_pop,
  input  logic              host_abort,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
`ifdef FIX_BUF_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic [7:0]        status
);

  fix_rd_state_t     state_reg;
  logic [ADDR_W-1:0] index_reg;
  logic [ADDR_W-1:0] final_reg;
  logic [DATA_W-1:0] read_data_reg;
  logic              overrun_reg;
  logic              rd_grant;
  logic              busy;
`ifdef FIX_BUF_CHECKSUM_EN
  logic [7:0]        csum_reg;
`endif

  assign busy = (state_reg == FETCH) || (state_reg == WAIT) || (state_reg == HOLD);

  fix_buf_arb #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .rd_req      (state_reg == FETCH),
    .rd_addr     (index_reg),
    .rd_grant    (rd_grant),
    .par_wr_valid(par_wr_valid),
    .par_wr_addr (par_wr_addr),
    .par_wr_data (par_wr_data),
    .par_wr_ready(par_wr_ready),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      index_reg     <= '0;
      final_reg     <= '0;
      read_data_reg <= '0;
      overrun_reg   <= 1'b0;
`ifdef FIX_BUF_CHECKSUM_EN
      csum_reg      <= '0;
`endif
    end else if (host_abort) begin
      state_reg <= IDLE;
      index_reg <= '0;
`ifdef FIX_BUF_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      if (fix_message_sent && busy) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE, DONE: begin
          if (fix_message_sent) begin
            final_reg <= final_index;
            state_reg <= READY;
          end
        end
        READY: begin
          if (fix_message_sent) begin
            final_reg <= final_index;
          end
          if (host_start) begin
            state_reg   <= FETCH;
            index_reg   <= '0;
            overrun_reg <= 1'b0;
`ifdef FIX_BUF_CHECKSUM_EN
            csum_reg    <= '0;
`endif
          end
        end
        FETCH: begin
          if (rd_grant) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          read_data_reg <= ram_rdata;
          state_reg     <= HOLD;
        end
        HOLD: begin
          if (host_pop) begin
`ifdef FIX_BUF_CHECKSUM_EN
            csum_reg <= csum_reg + 8'(read_data_reg);
`endif
            // Compare before incrementing so a full-range index never wraps
            if (index_reg == final_reg) begin
              state_reg <= DONE;
            end else begin
              index_reg <= index_reg + ADDR_W'(1);
              state_reg <= FETCH;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign read_data  = read_data_reg;
  assign read_valid = (state_reg == HOLD);
`ifdef FIX_BUF_CHECKSUM_EN
  assign checksum   = csum_reg;
`endif

  always_comb begin
    status          = '0;
    status[ST_READY] = (state_reg == READY);
    status[ST_BUSY]  = busy;
    status[ST_DONE]  = (state_reg == DONE);
    status[ST_OVRN]  = overrun_reg;
`ifdef FIX_BUF_CHECKSUM_EN
    status[ST_CSUM]  = (state_reg == DONE) && (csum_reg == 8'd0);
`endif
  end

endmodule

// File: tb/tb_fix_buf_read_sched.sv
// Randomized self-checking bench for fix_buf_read_sched against a byte-level
// reference of the buffer contents, status flags and readout latencies.
module tb_fix_buf_read_sched;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              par_wr_valid;
  logic [ADDR_W-1:0] par_wr_addr;
  logic [DATA_W-1:0] par_wr_data;
  logic              par_wr_ready;
  logic              fix_message_sent;
  logic [ADDR_W-1:0] final_index;
  logic              host_start;
  logic              host_pop;
  logic              host_abort;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic [7:0]        status;
`ifdef FIX_BUF_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  always #5 clk = ~clk;

  fix_buf_read_sched #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .par_wr_valid    (par_wr_valid),
    .par_wr_addr     (par_wr_addr),
    .par_wr_data     (par_wr_data),
    .par_wr_ready    (par_wr_ready),
    .fix_message_sent(fix_message_sent),
    .final_index     (final_index),
    .host_start      (host_start),
    .host_pop        (host_pop),
    .host_abort      (host_abort),
    .ram_addr        (ram_addr),
    .ram_we          (ram_we),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata),
`ifdef FIX_BUF_CHECKSUM_EN
    .checksum        (checksum),
`endif
    .read_data       (read_data),
    .read_valid      (read_valid),
    .status          (status)
  );

  // Single-port synchronous RAM with registered read data
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] ref_mem [256];
  bit         ovr;
  logic [7:0] sum;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_status(input bit rdy, input bit bsy, input bit dn);
    logic [7:0] s;
    s = {4'b0, ovr, dn, bsy, rdy};
`ifdef FIX_BUF_CHECKSUM_EN
    s[4] = dn && (sum == 8'd0);
`endif
    return s;
  endfunction

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      par_wr_valid = 1'b1;
      par_wr_addr  = i[7:0];
      par_wr_data  = ref_mem[i];
      #1;
      chk("wr_ready", par_wr_ready, 1);
      @(negedge clk);
    end
    par_wr_valid = 1'b0;
  endtask

  task automatic announce(input int fin);
    fix_message_sent = 1'b1;
    final_index      = fin[7:0];
    @(negedge clk);
    fix_message_sent = 1'b0;
    chk("announce_status", status, exp_status(1, 0, 0));
  endtask

  task automatic wait_valid(input bit cont, input string tag);
    int c = 0;
    int z = 0;
    do begin
      @(negedge clk);
      host_start = 1'b0;
      host_pop   = 1'b0;
      c++;
      if (cont && !par_wr_ready) z++;
      if (c == 1 && $urandom_range(0, 3) == 0) host_pop = 1'b1;
    end while (!read_valid && c < 40);
    host_pop = 1'b0;
    chk({tag, "_latency"}, c, cont ? 3 + STARVE_MAX : 3);
    if (cont) chk({tag, "_stall_cycles"}, z, 1);
  endtask

  task automatic readout(input int n, input bit cont, input bit ovr_inj, input bit abort_at1);
    int d;
    if (cont) begin
      par_wr_valid = 1'b1;
      par_wr_addr  = 8'(200 + $urandom_range(0, 50));
      par_wr_data  = 8'($urandom);
    end
    host_start = 1'b1;
    ovr = 1'b0;
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      wait_valid(cont, (i == 0) ? "start" : "pop");
      chk("rdata", read_data, ref_mem[i]);
      chk("hold_status", status, exp_status(0, 1, 0));
      if (ovr_inj && i == 2) begin
        fix_message_sent = 1'b1;
        final_index      = 8'd9;
        @(negedge clk);
        fix_message_sent = 1'b0;
        ovr = 1'b1;
        chk("overrun_status", status, exp_status(0, 1, 0));
      end
      d = $urandom_range(0, 2);
      repeat (d) @(negedge clk);
      chk("held_valid", read_valid, 1);
      chk("held_data", read_data, ref_mem[i]);
      if (abort_at1 && i == 1) begin
        host_abort = 1'b1;
        host_pop   = 1'b1;
        @(negedge clk);
        host_abort   = 1'b0;
        host_pop     = 1'b0;
        par_wr_valid = 1'b0;
        chk("abort_status", status, exp_status(0, 0, 0));
        chk("abort_valid", read_valid, 0);
`ifdef FIX_BUF_CHECKSUM_EN
        chk("abort_csum", checksum, 0);
`endif
        return;
      end
      host_pop = 1'b1;
      sum = sum + ref_mem[i];
      if (i == n - 1) begin
        @(negedge clk);
        host_pop = 1'b0;
        chk("done_status", status, exp_status(0, 0, 1));
        chk("done_valid", read_valid, 0);
`ifdef FIX_BUF_CHECKSUM_EN
        chk("csum", checksum, sum);
`endif
      end
    end
    par_wr_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    par_wr_valid = 1'b1; par_wr_addr = 8'h55; par_wr_data = 8'hA5;
    fix_message_sent = 1'b0; final_index = '0;
    host_start = 1'b0; host_pop = 1'b0; host_abort = 1'b0;
    ovr = 1'b0; sum = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", par_wr_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_status", status, 0);
    chk("rst_valid", read_valid, 0);
    par_wr_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_status", status, 0);
    chk("post_rst_rdata", read_data, 0);
    chk("post_rst_addr", ram_addr, 0);

    // Uncontended readout; simultaneous message+start in IDLE only latches
    ref_mem[0] = 8'h38; ref_mem[1] = 8'h3D; ref_mem[2] = 8'h46; ref_mem[3] = 8'h49;
    load(4);
    fix_message_sent = 1'b1; host_start = 1'b1; final_index = 8'd3;
    @(negedge clk);
    fix_message_sent = 1'b0; host_start = 1'b0;
    chk("latch_only", status, exp_status(1, 0, 0));
    repeat (2) @(negedge clk);
    chk("start_ignored", status, exp_status(1, 0, 0));
    readout(4, 0, 0, 0);
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
    @(negedge clk);
    chk("start_in_done", status, exp_status(0, 0, 1));

    // Contention, overrun, abort
    announce(3); readout(4, 1, 0, 0);
    announce(3); readout(4, 0, 1, 0);
    announce(3); readout(4, 0, 0, 0);
    announce(3); readout(4, 0, 0, 1);
    announce(3); readout(4, 0, 0, 0);

    // Single-byte message
    ref_mem[0] = 8'hAA;
    load(1); announce(0); readout(1, 0, 0, 0);

    // Checksum patterns
    ref_mem[0] = 8'h10; ref_mem[1] = 8'h20; ref_mem[2] = 8'hD0;
    load(3); announce(2); readout(3, 0, 0, 0);
    ref_mem[0] = 8'h01; ref_mem[1] = 8'h02;
    load(2); announce(1); readout(2, 0, 0, 0);

    // Randomized messages
    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) ref_mem[i] = 8'($urandom);
      load(n);
      announce(n - 1);
      readout(n, 1'($urandom_range(0, 1)), (n >= 4) && ($urandom_range(0, 3) == 0),
              (n >= 2) && ($urandom_range(0, 4) == 0));
    end

    // Reset mid-readout leaves RAM contents intact
    for (int i = 0; i < 5; i++) ref_mem[i] = 8'($urandom);
    load(5); announce(4);
    host_start = 1'b1;
    wait_valid(0, "pre_reset");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ovr = 1'b0;
    @(negedge clk);
    chk("midrst_status", status, 0);
    chk("midrst_valid", read_valid, 0);
`ifdef FIX_BUF_CHECKSUM_EN
    chk("midrst_csum", checksum, 0);
`endif
    announce(4); readout(5, 0, 0, 0);

    // Full address range: index must stop at 255 without wrapping
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    load(256); announce(255); readout(256, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("full_range_done", status, exp_status(0, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
